// File: rtl/riscv_pkg.sv
// Shared RV32I core types and constants.
// Fetch buffer entries pair each instruction word with the PC it was fetched from.
package riscv_pkg;

    localparam int unsigned INSTR_BYTES      = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetched entries with push, pop, flush and a registered head.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH       = 4,
    parameter type         entry_t     = fetch_entry_t,
    parameter entry_t      RESET_ENTRY = '0,
    localparam int unsigned PTR_W      = $clog2(DEPTH),
    localparam int unsigned CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  entry_t           i_push_data,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [CNT_W-1:0] o_count,
    output entry_t           o_head
);

    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    entry_t           r_mem [DEPTH];
    logic             w_pop;

    assign w_pop = i_pop && (r_count != '0);

    // Flush only rewinds the pointers; stale storage is hidden by a zero count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= RESET_ENTRY;
            end
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + CNT_W'(i_push) - CNT_W'(w_pop);
        end
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// RV32I fetch front end: PC, credit-limited request issue, stale-response discard
// after redirects, and a buffered valid/ready instruction stream.
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc
);

    localparam int unsigned  CNT_W       = $clog2(DEPTH) + 1;
    // Repeated redirects can stack stale responses beyond one buffer's worth.
    localparam int unsigned  DISC_W      = CNT_W + 3;
    localparam logic [CNT_W:0] DEPTH_C   = (CNT_W + 1)'(DEPTH);
    localparam logic [31:0]  PC_STEP     = 32'(INSTR_BYTES);
    localparam fetch_entry_t RESET_ENTRY = '{pc: RESET_PC, instr: 32'h0};

    logic [31:0]       r_pc;
    logic [31:0]       r_resp_pc;
    logic [CNT_W-1:0]  r_inflight;
    logic [DISC_W-1:0] r_discard;

    logic [CNT_W-1:0]  w_count;
    logic [CNT_W:0]    w_credit_used;
    logic [31:0]       w_redirect_pc;
    logic              w_issue;
    logic              w_rsp_live;
    logic              w_rsp_drop;
    logic              w_rsp_any;
    logic              w_push;
    logic              w_pop;
    logic [DISC_W-1:0] w_discard_redirect;
    fetch_entry_t      w_push_entry;
    fetch_entry_t      w_head;

    assign w_redirect_pc = redirect_pc & 32'hFFFF_FFFC;
    assign w_credit_used = {1'b0, w_count} + {1'b0, r_inflight};

    assign imem_req  = !reset && !redirect_valid && (w_credit_used < DEPTH_C);
    assign imem_addr = r_pc;
    assign w_issue   = imem_req && imem_gnt;

    // Responses with nothing outstanding are protocol errors and are ignored.
    assign w_rsp_drop = imem_rvalid && (r_discard != '0);
    assign w_rsp_live = imem_rvalid && (r_discard == '0) && (r_inflight != '0);
    assign w_rsp_any  = w_rsp_drop || w_rsp_live;

    assign w_push       = w_rsp_live && !redirect_valid;
    assign w_pop        = instr_valid && instr_ready;
    assign w_push_entry = '{pc: r_resp_pc, instr: imem_rdata};

    assign w_discard_redirect = r_discard + DISC_W'(r_inflight) - DISC_W'(w_rsp_any);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc       <= RESET_PC;
            r_resp_pc  <= RESET_PC;
            r_inflight <= '0;
            r_discard  <= '0;
        end else if (redirect_valid) begin
            r_pc       <= w_redirect_pc;
            r_resp_pc  <= w_redirect_pc;
            r_inflight <= '0;
            r_discard  <= w_discard_redirect;
        end else begin
            if (w_issue) begin
                r_pc <= r_pc + PC_STEP;
            end
            if (w_rsp_live) begin
                r_resp_pc <= r_resp_pc + PC_STEP;
            end
            if (w_rsp_drop) begin
                r_discard <= r_discard - DISC_W'(1);
            end
            r_inflight <= r_inflight + CNT_W'(w_issue) - CNT_W'(w_rsp_live);
        end
    end

    fetch_fifo #(
        .DEPTH       (DEPTH),
        .entry_t     (fetch_entry_t),
        .RESET_ENTRY (RESET_ENTRY)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .i_flush     (redirect_valid),
        .o_count     (w_count),
        .o_head      (w_head)
    );

    assign instr_valid = (w_count != '0);
    assign instr_data  = w_head.instr;
    assign instr_pc    = w_head.pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: in-order memory model with configurable latency, an
// epoch-tagged expected-output queue, per-cycle compare, and directed literal checks.
module tb_instr_fetch_unit;
    import riscv_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b1;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;

    // Second instance for PC wrap, fed by a fixed 1-cycle loopback memory.
    logic        w_reset = 1'b1;
    logic        w_req;
    logic [31:0] w_addr;
    logic        w_rv = 1'b0;
    logic [31:0] w_ra = '0;
    logic        w_valid;
    logic [31:0] w_data;
    logic [31:0] w_pc;

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(RPC), .DEPTH(DEPTH)) u_dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) u_dut_wrap (
        .clk            (clk),
        .reset          (w_reset),
        .imem_req       (w_req),
        .imem_addr      (w_addr),
        .imem_gnt       (1'b1),
        .imem_rvalid    (w_rv),
        .imem_rdata     (word(w_ra)),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
        .instr_valid    (w_valid),
        .instr_ready    (1'b1),
        .instr_data     (w_data),
        .instr_pc       (w_pc)
    );

    always @(posedge clk) begin
        w_rv <= w_req;
        w_ra <= w_addr;
    end

    int checks = 0;
    int failures = 0;

    typedef struct { logic [31:0] addr; int ep; int due; } mreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } out_t;

    mreq_t       memq [$];
    out_t        outq [$];
    logic [31:0] seen [$];
    logic [31:0] mpc = RPC;
    int          epoch = 0;
    int          cyc = 0;
    int          lat = 1;
    logic [31:0] cur_addr = '0;
    int          cur_ep = -1;
    logic        s_req = 1'b0;
    logic        s_valid = 1'b0;
    logic [31:0] s_pc = '0;

    function automatic logic [31:0] word(input logic [31:0] a);
        return {a[24:0], 7'h13};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int live_inflight();
        int n = 0;
        foreach (memq[i]) if (memq[i].ep == epoch) n++;
        if (imem_rvalid && cur_ep == epoch) n++;
        return n;
    endfunction

    // Per-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        logic exp_req;
        s_req   = imem_req;
        s_valid = instr_valid;
        s_pc    = instr_pc;
        if (reset) begin
            check("req_in_reset", imem_req, 1'b0);
        end else begin
            exp_req = !redirect_valid && ((outq.size() + live_inflight()) < DEPTH);
            check("imem_req", imem_req, exp_req);
            check("imem_addr", imem_addr, mpc);
            check("instr_valid", instr_valid, outq.size() != 0);
            if (outq.size() != 0) begin
                check("instr_pc", instr_pc, outq[0].pc);
                check("instr_data", instr_data, outq[0].instr);
            end
        end
    end

    // Advance one clock, update the model with the cycle just ended, present memory.
    task automatic step();
        @(posedge clk);
        if (reset) begin
            outq.delete();
            memq.delete();
            mpc = RPC;
            epoch++;
        end else begin
            if (s_valid && instr_ready && !redirect_valid) begin
                seen.push_back(s_pc);
                if (outq.size() != 0) void'(outq.pop_front());
            end
            if (imem_rvalid && !redirect_valid && cur_ep == epoch)
                outq.push_back('{pc: cur_addr, instr: word(cur_addr)});
            if (s_req && imem_gnt) begin
                memq.push_back('{addr: mpc, ep: epoch, due: cyc + lat});
                mpc = mpc + 32'd4;
            end
            if (redirect_valid) begin
                outq.delete();
                epoch++;
                mpc = redirect_pc & 32'hFFFF_FFFC;
            end
        end
        cyc++;
        #1;
        imem_rvalid = 1'b0;
        cur_ep = -1;
        if (!reset && memq.size() != 0 && memq[0].due <= cyc) begin
            mreq_t m;
            m = memq.pop_front();
            imem_rvalid = 1'b1;
            imem_rdata  = word(m.addr);
            cur_addr    = m.addr;
            cur_ep      = m.ep;
        end
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        redirect_valid = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        bit ok = 0;
        for (int i = 0; i < 30; i++) begin
            if (instr_valid) begin
                ok = 1;
                break;
            end
            step();
            settle();
        end
        check(name, ok, 1'b1);
    endtask

    initial begin
        int nreq;
        step();
        step();
        settle();
        check("rst_valid", instr_valid, 1'b0);
        check("rst_pc", instr_pc, RPC);
        check("rst_data", instr_data, 32'h0);
        check("rst_addr", imem_addr, RPC);
        check("rst_req", imem_req, 1'b0);

        // Streaming: latency 1, grant and ready high.
        reset = 1'b0;
        settle();
        check("t1_addr_c1", imem_addr, 32'h0);
        step(); settle();
        check("t1_addr_c2", imem_addr, 32'h4);
        step(); settle();
        check("t1_addr_c3", imem_addr, 32'h8);
        check("t1_valid_c3", instr_valid, 1'b1);
        check("t1_pc_c3", instr_pc, 32'h0);
        check("t1_data_c3", instr_data, 32'h0000_0013);
        step(); settle();
        check("t1_pc_c4", instr_pc, 32'h4);
        check("t1_data_c4", instr_data, 32'h0000_0213);
        for (int i = 0; i < 8; i++) step();

        // Backpressure: exactly DEPTH requests accepted, then drain in order.
        instr_ready = 1'b0;
        reset_pulse();
        seen.delete();
        nreq = 0;
        for (int i = 0; i < 8; i++) begin
            settle();
            if (imem_req) nreq++;
            step();
        end
        settle();
        check("t2_nreq", nreq, 4);
        check("t2_req_off", imem_req, 1'b0);
        check("t2_valid", instr_valid, 1'b1);
        check("t2_head_pc", instr_pc, 32'h0);
        instr_ready = 1'b1;
        for (int i = 0; i < 8; i++) step();
        check("t2_drained", seen.size() >= 4, 1'b1);
        for (int i = 0; i < 4; i++)
            if (i < seen.size()) check("t2_order", seen[i], 32'(i * 4));

        // Grant stall holds address.
        reset_pulse();
        step();
        step();
        imem_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("t3_stall_addr", imem_addr, 32'h8);
            check("t3_stall_req", imem_req, 1'b1);
            step();
        end
        imem_gnt = 1'b1;
        settle();
        check("t3_grant_addr", imem_addr, 32'h8);
        step(); settle();
        check("t3_next_addr", imem_addr, 32'hC);
        for (int i = 0; i < 6; i++) step();

        // Redirect with two requests in flight, latency 3.
        lat = 3;
        reset_pulse();
        step();
        step();
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        step();
        redirect_valid = 1'b0;
        settle();
        check("t4_empty", instr_valid, 1'b0);
        check("t4_req", imem_req, 1'b1);
        check("t4_addr", imem_addr, 32'h100);
        wait_valid("t4_wait");
        check("t4_first_pc", instr_pc, 32'h100);
        for (int i = 0; i < 10; i++) step();

        // Redirect coinciding with a response, then a second redirect (low bits forced).
        lat = 2;
        reset_pulse();
        begin
            bit hit = 0;
            for (int i = 0; i < 10; i++) begin
                if (imem_rvalid) begin
                    hit = 1;
                    break;
                end
                step();
            end
            check("t5_rvalid_seen", hit, 1'b1);
        end
        redirect_valid = 1'b1;
        redirect_pc = 32'h180;
        step();
        redirect_pc = 32'h203;
        step();
        redirect_valid = 1'b0;
        settle();
        wait_valid("t5_wait");
        check("t5_first_pc", instr_pc, 32'h200);
        check("t5_first_data", instr_data, word(32'h200));
        seen.delete();
        for (int i = 0; i < 12; i++) step();
        check("t5_stream", seen.size() >= 4, 1'b1);
        if (seen.size() >= 4) check("t5_stream_pc3", seen[3], 32'h20C);

        // Reset mid-stream.
        lat = 1;
        reset = 1'b1;
        settle();
        check("t6_req_in_reset", imem_req, 1'b0);
        step();
        reset = 1'b0;
        settle();
        check("t6_valid", instr_valid, 1'b0);
        check("t6_req", imem_req, 1'b1);
        check("t6_addr", imem_addr, RPC);
        wait_valid("t6_wait");
        check("t6_first_pc", instr_pc, RPC);

        // PC wrap on the second instance.
        w_reset = 1'b0;
        settle();
        check("wrap_addr_c1", w_addr, 32'hFFFF_FFF8);
        step(); settle();
        check("wrap_addr_c2", w_addr, 32'hFFFF_FFFC);
        step(); settle();
        check("wrap_addr_c3", w_addr, 32'h0);
        check("wrap_valid_c3", w_valid, 1'b1);
        check("wrap_pc_c3", w_pc, 32'hFFFF_FFF8);
        step(); settle();
        check("wrap_pc_c4", w_pc, 32'hFFFF_FFFC);
        step(); settle();
        check("wrap_pc_c5", w_pc, 32'h0);
        check("wrap_data_c5", w_data, 32'h0000_0013);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL timeout: got running expected finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
